// File: rtl/fwd_select_ctrl.sv
// Operand-forwarding select generator and load-use stall detector for the two ALU operand muxes.
// Selects are registered so they line up with the instruction once it has moved into EX.
module fwd_select_ctrl #(
    parameter int          REG_W    = 5,
    parameter int unsigned ZERO_REG = 31
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rn,
    input  logic [REG_W-1:0] id_rm,
    input  logic             id_use_imm,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    input  logic             flush,
    output logic [1:0]       sel_a,
    output logic [1:0]       sel_b,
    output logic             stall
);

    localparam logic [REG_W-1:0] ZR = REG_W'(ZERO_REG);

    localparam logic [1:0] SEL_RF  = 2'b00;
    localparam logic [1:0] SEL_EX  = 2'b01;
    localparam logic [1:0] SEL_MEM = 2'b10;
    localparam logic [1:0] SEL_IMM = 2'b11;

    // Only EX and MEM writers feed a mux input; a WB-stage writer reaches the
    // operand through the register file's write-through, so no WB slot is kept.
    logic [REG_W-1:0] ex_rd_q, ex_rd_d;
    logic             ex_wr_q, ex_wr_d;
    logic             ex_ld_q, ex_ld_d;
    logic [REG_W-1:0] mem_rd_q;
    logic             mem_wr_q;
    logic [1:0]       sel_a_q, sel_a_d;
    logic [1:0]       sel_b_q, sel_b_d;

    logic ex_hit_a, ex_hit_b, mem_hit_a, mem_hit_b;
    logic bubble;

    assign ex_hit_a  = ex_wr_q  && (ex_rd_q  == id_rn) && (id_rn != ZR);
    assign ex_hit_b  = ex_wr_q  && (ex_rd_q  == id_rm) && (id_rm != ZR);
    assign mem_hit_a = mem_wr_q && (mem_rd_q == id_rn) && (id_rn != ZR);
    assign mem_hit_b = mem_wr_q && (mem_rd_q == id_rm) && (id_rm != ZR);

    assign stall  = id_valid && ex_ld_q && (ex_hit_a || (!id_use_imm && ex_hit_b));
    assign bubble = stall || flush || !id_valid;

    always_comb begin
        ex_rd_d = id_rd;
        ex_wr_d = id_reg_write && !bubble;
        ex_ld_d = id_mem_read && !bubble;
        sel_a_d = SEL_RF;
        sel_b_d = SEL_RF;
        if (!bubble) begin
            if (ex_hit_a)       sel_a_d = SEL_EX;
            else if (mem_hit_a) sel_a_d = SEL_MEM;

            if (id_use_imm)     sel_b_d = SEL_IMM;
            else if (ex_hit_b)  sel_b_d = SEL_EX;
            else if (mem_hit_b) sel_b_d = SEL_MEM;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ex_rd_q  <= '0;
            ex_wr_q  <= 1'b0;
            ex_ld_q  <= 1'b0;
            mem_rd_q <= '0;
            mem_wr_q <= 1'b0;
            sel_a_q  <= SEL_RF;
            sel_b_q  <= SEL_RF;
        end else begin
            ex_rd_q  <= ex_rd_d;
            ex_wr_q  <= ex_wr_d;
            ex_ld_q  <= ex_ld_d;
            mem_rd_q <= ex_rd_q;
            mem_wr_q <= ex_wr_q;
            sel_a_q  <= sel_a_d;
            sel_b_q  <= sel_b_d;
        end
    end

    assign sel_a = sel_a_q;
    assign sel_b = sel_b_q;

endmodule
